// File: rtl/serializador_registrador.sv
// -----------------------------------------------------------------------------
// serializador_registrador
//
// Parallel-in/serial-out reader for the ALU result register. A word is taken
// from the register side with a load handshake, then shifted out LSB-first,
// one bit per accepted transfer on the serial valid/ready handshake. A
// one-cycle fim pulse follows the last transferred bit.
//
// Optional feature (compile-time macro SERIAL_PARIDADE_EN):
//   When defined, an even parity bit (XOR of the loaded word) is sent as an
//   extra bit after the data, so the word on the wire is LARGURA+1 bits long.
//
// Parameters:
//   LARGURA       data word width in bits (>= 2)
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   reset         synchronous, active-high reset
//   dado_in       parallel word to serialize
//   carga         load request; word taken when carga && pronto_carga
//   pronto_carga  block idle, a new word can be loaded
//   saida_serial  current serial bit
//   saida_valida  saida_serial holds a valid bit
//   saida_pronta  consumer ready; bit transferred when saida_valida && saida_pronta
//   fim           one-cycle pulse after the last bit has transferred
//
// All outputs are decoded from registered state; carga and saida_pronta only
// steer the next state, never an output in the same cycle.
// -----------------------------------------------------------------------------
module serializador_registrador #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] dado_in,
  input  logic               carga,
  output logic               pronto_carga,
  output logic               saida_serial,
  output logic               saida_valida,
  input  logic               saida_pronta,
  output logic               fim
);

  localparam int               CW     = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0]    ULTIMO = CW'(LARGURA - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCANDO,
    FIM
`ifdef SERIAL_PARIDADE_EN
    ,
    PARIDADE
`endif
  } estado_t;

  estado_t            estado;
  estado_t            proximo;
  logic [LARGURA-1:0] shift_reg;
  logic [CW-1:0]      contador;
  logic               carregar;
  logic               deslocar;
`ifdef SERIAL_PARIDADE_EN
  logic               paridade;
`endif

  // Handshake qualifiers: a load only counts while idle, a shift only while
  // data bits are being presented.
  assign carregar = (estado == OCIOSO) && carga;
  assign deslocar = (estado == DESLOCANDO) && saida_pronta;

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // NOTE: the shift register is a plain data register, but it is still reset
  // so an aborted word never leaks stale bits onto saida_serial.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      contador  <= '0;
`ifdef SERIAL_PARIDADE_EN
      paridade  <= 1'b0;
`endif
    end else if (carregar) begin
      shift_reg <= dado_in;
      contador  <= '0;
`ifdef SERIAL_PARIDADE_EN
      paridade  <= ^dado_in;
`endif
    end else if (deslocar) begin
      shift_reg <= {1'b0, shift_reg[LARGURA-1:1]};
      contador  <= (contador == ULTIMO) ? '0 : contador + 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    proximo      = estado;
    pronto_carga = 1'b0;
    saida_valida = 1'b0;
    saida_serial = 1'b0;
    fim          = 1'b0;
    case (estado)
      OCIOSO: begin
        pronto_carga = 1'b1;
        if (carga) proximo = DESLOCANDO;
      end
      DESLOCANDO: begin
        saida_valida = 1'b1;
        saida_serial = shift_reg[0];
        if (saida_pronta && (contador == ULTIMO)) begin
`ifdef SERIAL_PARIDADE_EN
          proximo = PARIDADE;
`else
          proximo = FIM;
`endif
        end
      end
`ifdef SERIAL_PARIDADE_EN
      PARIDADE: begin
        saida_valida = 1'b1;
        saida_serial = paridade;
        if (saida_pronta) proximo = FIM;
      end
`endif
      FIM: begin
        fim     = 1'b1;
        proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

endmodule
